ahbl_to_apb_bridge: RTL and testbench
=====================================

Name: ahbl_to_apb_bridge

Overview:
AHB-Lite slave to APB3 master bridge. It sits directly downstream of the AHB-Lite BFM master and converts each AHB-Lite single transfer into one APB3 transfer toward the CoreUARTapb register file. The AHB bus is held with HREADYOUT low until the APB transfer completes. PSLVERR is mapped to a two-cycle AHB ERROR response.

Parameters:
APB_AWIDTH, 12, PADDR width; PADDR = HADDR[APB_AWIDTH-1:0].
TIMEOUT_CYCLES, 255, ACCESS-phase cycles before forced abort. Used only with APB_TIMEOUT_EN; legal range 1..65535.

Ports:
HCLK  in  1  single clock for both AHB and APB sides.
HRESETN  in  1  reset, synchronous, active-low.
HSEL  in  1  slave select.
HADDR  in  32  AHB address.
HTRANS  in  2  transfer type; only NONSEQ/SEQ (bit1=1) are active.
HWRITE  in  1  write when 1.
HSIZE  in  3  ignored; every transfer is forwarded as a full 32-bit access.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus-level ready (HREADYIN).
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data, registered.
PADDR  out  APB_AWIDTH  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  32  APB write data.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB error.

Behaviour:
- Clock and reset: single clock HCLK. HRESETN is synchronous and active-low. All state is updated only on rising HCLK; no asynchronous paths.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, state=IDLE.
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge while in IDLE or ERR2. On accept, latch HADDR and HWRITE. IDLE/BUSY transfers are ignored and get zero-wait OKAY.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On accept: write goes to WDATA, read goes to SETUP.
  - WDATA: HREADYOUT=0. Capture HWDATA into PWDATA, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
    - PREADY=1 and PSLVERR=0: next IDLE with HREADYOUT=1. For reads, HRDATA <= PRDATA on the same edge.
    - PREADY=1 and PSLVERR=1: next ERR1.
    - PREADY=0: stay in ACCESS.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept is allowed here; otherwise go to IDLE.
- Outputs: PSEL, PENABLE and HREADYOUT are registered outputs decoded from state.
- Latency with PREADY tied high:
  - Read: T0 address phase, T1 SETUP, T2 ACCESS, T3 HREADYOUT=1 with HRDATA valid. Two wait states.
  - Write: one extra cycle for WDATA, so three wait states.
- Stability: PADDR, PWRITE and PWDATA stay stable from SETUP through the last ACCESS cycle. After completion they hold their last values (PSEL=0).
- Back-to-back: a transfer accepted in the completion cycle starts immediately; there is no idle cycle on the APB side beyond the APB-required deassertion of PENABLE.
- HRDATA holds its last read value across writes and errors.
- Reset mid-transfer: at the next edge with HRESETN=0, PSEL and PENABLE drop, the state returns to IDLE and the AHB transfer is discarded.

Optional Feature:
Macro APB_TIMEOUT_EN.
- When defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, go to ERR1 (PSEL/PENABLE drop), the read leaves HRDATA unchanged, and a sticky TIMEOUT_FLAG output (1 bit, reset 0, cleared by reset only) is set.
- When undefined: no counter, no TIMEOUT_FLAG port, and ACCESS waits indefinitely.

Decomposition:
- Package ahbl_apb_pkg holds: HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP encodings, the state enum {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2}, and the timeout counter width constant (16).
- Sub-module apb_timeout_ctr holds the counter plus the terminal-count compare, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Read 0x0000_0014, PREADY=1, PRDATA=0xA5 -> PSEL high 2 cycles, PADDR=0x014, HREADYOUT low 2 cycles, HRDATA=0x0000_00A5, HRESP=0.
- Write 0x0000_0000 data 0x55 -> WDATA cycle, then PWDATA=0x55 and PWRITE=1 through SETUP/ACCESS, 3 wait states, OKAY.
- Read with PREADY low 4 ACCESS cycles -> PENABLE high 5 cycles, PADDR stable throughout, HREADYOUT low 6 cycles total.
- Write with PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a NONSEQ read issued during ERR2 is accepted and completes OKAY.
- Back-to-back read/read/write plus an IDLE transfer with HSEL=1 -> the IDLE transfer gets zero-wait OKAY with no PSEL; APB sequence correct with PENABLE deasserted between transfers.
- HRESETN low during ACCESS -> PSEL=0 and PENABLE=0 at the next edge, HREADYOUT=1. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY stuck low -> ERROR after 8 ACCESS cycles and TIMEOUT_FLAG=1.

Source files
------------

// File: rtl/ahbl_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB3 bridge: AHB transfer and
// response encodings, the bridge state enum and the timeout counter width.
package ahbl_apb_pkg;

    // AHB-Lite HTRANS encodings; bit 1 set marks an active transfer
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB-Lite HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of the ACCESS-phase timeout counter
    localparam int TMO_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    // True for NONSEQ and SEQ transfers
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the cycle
// in which the stall reaches TIMEOUT_CYCLES.
module apb_timeout_ctr
    import ahbl_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam logic [TMO_CNT_W-1:0] TERM = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    // Clear when ACCESS is about to be entered, count each stalled ACCESS cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + TMO_CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The stalled cycle that would make the count reach TIMEOUT_CYCLES aborts
    assign expire_o = count_i && (cnt_q == TERM);

endmodule

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge. Each active AHB single transfer
// becomes one APB3 transfer; HREADYOUT stays low until the APB side
// completes and PSLVERR turns into a two-cycle AHB ERROR response.
// Optional ACCESS-phase timeout with sticky TIMEOUT_FLAG: define APB_TIMEOUT_EN.
module ahbl_to_apb_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int APB_AWIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
`ifdef APB_TIMEOUT_EN
    ,
    output logic                  TIMEOUT_FLAG
`endif
);

    bridge_state_e state_q;
    bridge_state_e state_d;

    logic [APB_AWIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [31:0]           pwdata_q;
    logic [31:0]           hrdata_q;

    logic accept;
    logic apb_done;
    logic tmo_expire;

    // HSIZE is ignored (always full-word) and only the low address bits reach APB
    logic unused_bits;
    assign unused_bits = ^{HSIZE, HTRANS[0], HADDR};

    assign accept   = HSEL && htrans_active(HTRANS) && HREADY &&
                      ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    assign apb_done = (state_q == ST_ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
    logic timeout_flag_q;

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (HCLK),
        .rst_ni  (HRESETN),
        .clear_i (state_q == ST_SETUP),
        .count_i ((state_q == ST_ACCESS) && !PREADY),
        .expire_o(tmo_expire)
    );

    // Sticky record that an APB access was aborted; only reset clears it
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            timeout_flag_q <= 1'b0;
        end else if (tmo_expire) begin
            timeout_flag_q <= 1'b1;
        end
    end

    assign TIMEOUT_FLAG = timeout_flag_q;
`else
    assign tmo_expire = 1'b0;
`endif

    // Next-state decode of the transfer sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    state_d = HWRITE ? ST_WDATA : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
                end else if (tmo_expire) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any transfer in flight
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // APB address/data capture and AHB read-data return
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= HADDR[APB_AWIDTH-1:0];
                pwrite_q <= HWRITE;
            end
            if (state_q == ST_WDATA) begin
                pwdata_q <= HWDATA;
            end
            if (apb_done && !PSLVERR && !pwrite_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    // Bus controls come straight from the state register
    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
module tb_ahbl_to_apb_bridge;

    localparam int AW  = 12;
    localparam int TMO = 8;
    localparam int STUCK = 1000000;

    logic          HCLK;
    logic          HRESETN;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
`ifdef APB_TIMEOUT_EN
    logic          TIMEOUT_FLAG;
`endif

    // Single-slave system: bus ready is the slave's own ready
    assign HREADY = HREADYOUT;

    ahbl_to_apb_bridge #(
        .APB_AWIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK     (HCLK),
        .HRESETN  (HRESETN),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .HRDATA   (HRDATA),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
`ifdef APB_TIMEOUT_EN
        ,
        .TIMEOUT_FLAG(TIMEOUT_FLAG)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wdata;
    } apb_t;

    apb_t        apb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          psel_cnt = 0;
    int          pen_cnt  = 0;
    logic [31:0] model_hrdata = 32'h0;

    // APB slave behaviour, configured per transfer
    int          slv_waits = 0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // APB slave: holds PREADY low for slv_waits ACCESS cycles, then completes
    initial begin
        int acc;
        acc = 0;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        PRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            #1;
            if (PSEL && PENABLE) begin
                if (acc >= slv_waits) begin
                    PREADY  = 1'b1;
                    PSLVERR = slv_err;
                    PRDATA  = slv_rdata;
                end else begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'($urandom);
                    PRDATA  = $urandom;
                end
                acc++;
            end else begin
                acc     = 0;
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end
    end

    // APB monitor: counts select/enable cycles, checks address/control/data
    // stability from SETUP through ACCESS and logs completed transfers
    initial begin
        logic [AW-1:0] cap_addr;
        logic          cap_wr;
        logic [31:0]   cap_wd;
        apb_t          e;
        cap_addr = '0;
        cap_wr   = 1'b0;
        cap_wd   = '0;
        forever begin
            @(negedge HCLK);
            if (PSEL) psel_cnt++;
            if (PENABLE) pen_cnt++;
            if (PSEL && !PENABLE) begin
                cap_addr = PADDR;
                cap_wr   = PWRITE;
                cap_wd   = PWDATA;
            end else if (PSEL && PENABLE) begin
                n_tests++;
                if ({PADDR, PWRITE, PWDATA} !== {cap_addr, cap_wr, cap_wd}) begin
                    n_fail++;
                    $display("FAIL apb_stable: got addr=%h wr=%b wd=%h required addr=%h wr=%b wd=%h",
                             PADDR, PWRITE, PWDATA, cap_addr, cap_wr, cap_wd);
                end
                if (PREADY) begin
                    e.addr  = PADDR;
                    e.wr    = PWRITE;
                    e.wdata = PWDATA;
                    apb_q.push_back(e);
                end
            end
        end
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before time limit");
        $fatal(1, "time limit");
    end

    // Issue one AHB transfer starting in the current (ready) cycle; returns at
    // the negedge of the cycle in which HREADYOUT comes back high
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic err, input logic [31:0] rdat,
                           output int nwait, output logic resp, output logic [31:0] rdata);
        bit done;
        slv_waits = waits;
        slv_err   = err;
        slv_rdata = rdat;
        psel_cnt  = 0;
        pen_cnt   = 0;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = 3'($urandom);
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HWDATA = wdata;
        nwait  = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) done = 1'b1;
            else nwait++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_timeout: got no HREADYOUT after %0d cycles, required completion", nwait);
        end
        resp  = HRESP;
        rdata = HRDATA;
        $display("[TB] xfer %s addr=%h wdata=%h waits=%0d err=%0b -> wait_states=%0d hresp=%0b hrdata=%h",
                 wr ? "W" : "R", addr, wdata, waits, err, nwait, resp, rdata);
    endtask

    task automatic test_reset();
        HRESETN = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'h0;
        repeat (3) @(negedge HCLK);
        n_tests++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hready_hresp: got %b/%b required 1/0", HREADYOUT, HRESP);
        end
        n_tests++;
        if (HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hrdata: got %h required 0", HRDATA);
        end
        n_tests++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_apb_ctrl: got psel=%b pen=%b pwrite=%b required 0/0/0", PSEL, PENABLE, PWRITE);
        end
        n_tests++;
        if (PADDR !== '0 || PWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_apb_data: got paddr=%h pwdata=%h required 0/0", PADDR, PWDATA);
        end
        HRESETN = 1'b1;
        @(negedge HCLK);
        apb_q.delete();
        model_hrdata = 32'h0;
    endtask

    task automatic test_read_basic();
        int nw; logic rs; logic [31:0] rd; apb_t e;
        do_xfer(32'h0000_0014, 1'b0, 32'h0, 0, 1'b0, 32'h0000_00A5, nw, rs, rd);
        model_hrdata = 32'h0000_00A5;
        n_tests++;
        if (nw !== 2 || rs !== 1'b0 || rd !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL read_basic: got waits=%0d resp=%b hrdata=%h required 2/0/000000a5", nw, rs, rd);
        end
        n_tests++;
        if (psel_cnt != 2 || apb_q.size() != 1) begin
            n_fail++;
            $display("FAIL read_basic_apb: got psel_cycles=%0d apb_xfers=%0d required 2/1", psel_cnt, apb_q.size());
        end else begin
            e = apb_q.pop_front();
            n_tests++;
            if (e.addr !== 12'h014 || e.wr !== 1'b0) begin
                n_fail++;
                $display("FAIL read_basic_paddr: got %h wr=%b required 014 wr=0", e.addr, e.wr);
            end
        end
    endtask

    task automatic test_write_basic();
        int nw; logic rs; logic [31:0] rd; apb_t e;
        do_xfer(32'h0000_0000, 1'b1, 32'h0000_0055, 0, 1'b0, $urandom, nw, rs, rd);
        n_tests++;
        if (nw !== 3 || rs !== 1'b0 || rd !== model_hrdata) begin
            n_fail++;
            $display("FAIL write_basic: got waits=%0d resp=%b hrdata=%h required 3/0/%h", nw, rs, rd, model_hrdata);
        end
        n_tests++;
        if (apb_q.size() != 1) begin
            n_fail++;
            $display("FAIL write_basic_apb: got %0d apb xfers required 1", apb_q.size());
        end else begin
            e = apb_q.pop_front();
            if (e.addr !== 12'h000 || e.wr !== 1'b1 || e.wdata !== 32'h55) begin
                n_fail++;
                $display("FAIL write_basic_pwdata: got addr=%h wr=%b wd=%h required 000/1/00000055", e.addr, e.wr, e.wdata);
            end
        end
    endtask

    task automatic test_wait_states();
        int nw; logic rs; logic [31:0] rd; logic [31:0] addr; logic [31:0] dat; apb_t e;
        addr = $urandom;
        dat  = $urandom;
        do_xfer(addr, 1'b0, 32'h0, 4, 1'b0, dat, nw, rs, rd);
        model_hrdata = dat;
        n_tests++;
        if (nw !== 6 || rs !== 1'b0 || rd !== dat) begin
            n_fail++;
            $display("FAIL wait_states: got waits=%0d resp=%b hrdata=%h required 6/0/%h", nw, rs, rd, dat);
        end
        n_tests++;
        if (pen_cnt != 5 || psel_cnt != 6) begin
            n_fail++;
            $display("FAIL wait_states_apb: got penable=%0d psel=%0d required 5/6", pen_cnt, psel_cnt);
        end
        n_tests++;
        if (apb_q.size() != 1) begin
            n_fail++;
            $display("FAIL wait_states_count: got %0d apb xfers required 1", apb_q.size());
        end else begin
            e = apb_q.pop_front();
            if (e.addr !== addr[AW-1:0]) begin
                n_fail++;
                $display("FAIL wait_states_paddr: got %h required %h", e.addr, addr[AW-1:0]);
            end
        end
    endtask

    task automatic test_slverr_err2_read();
        int nw; logic rs; logic [31:0] rd; logic [31:0] dat;
        do_xfer($urandom, 1'b1, $urandom, 0, 1'b1, $urandom, nw, rs, rd);
        n_tests++;
        if (nw !== 4 || rs !== 1'b1 || rd !== model_hrdata) begin
            n_fail++;
            $display("FAIL slverr_write: got waits=%0d resp=%b hrdata=%h required 4/1/%h", nw, rs, rd, model_hrdata);
        end
        // Issued while the ERROR response's second cycle is on the bus
        dat = $urandom;
        do_xfer(32'h0000_0008, 1'b0, 32'h0, 0, 1'b0, dat, nw, rs, rd);
        model_hrdata = dat;
        n_tests++;
        if (nw !== 2 || rs !== 1'b0 || rd !== dat) begin
            n_fail++;
            $display("FAIL err2_read: got waits=%0d resp=%b hrdata=%h required 2/0/%h", nw, rs, rd, dat);
        end
        n_tests++;
        if (apb_q.size() != 2) begin
            n_fail++;
            $display("FAIL err2_apb: got %0d apb xfers required 2", apb_q.size());
        end
        apb_q.delete();
    endtask

    task automatic test_back_to_back();
        int nw; logic rs; logic [31:0] rd; logic [31:0] d0; logic [31:0] d1; logic [31:0] wd;
        d0 = $urandom; d1 = $urandom; wd = $urandom;
        do_xfer(32'h0000_0004, 1'b0, 32'h0, 0, 1'b0, d0, nw, rs, rd);
        n_tests++;
        if (nw !== 2 || rd !== d0) begin
            n_fail++;
            $display("FAIL b2b_read0: got waits=%0d hrdata=%h required 2/%h", nw, rd, d0);
        end
        do_xfer(32'h0000_000C, 1'b0, 32'h0, 0, 1'b0, d1, nw, rs, rd);
        n_tests++;
        if (nw !== 2 || rd !== d1 || pen_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_read1: got waits=%0d hrdata=%h penable=%0d required 2/%h/1", nw, rd, pen_cnt, d1);
        end
        do_xfer(32'h0000_0010, 1'b1, wd, 0, 1'b0, $urandom, nw, rs, rd);
        model_hrdata = d1;
        n_tests++;
        if (nw !== 3 || rs !== 1'b0 || rd !== d1) begin
            n_fail++;
            $display("FAIL b2b_write: got waits=%0d resp=%b hrdata=%h required 3/0/%h", nw, rs, rd, d1);
        end
        // IDLE transfer to this slave: zero-wait OKAY, nothing on APB
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'b1;
        psel_cnt = 0;
        @(negedge HCLK);
        HSEL = 1'b0;
        n_tests++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || psel_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_idle: got hready=%b hresp=%b psel_cycles=%0d required 1/0/0", HREADYOUT, HRESP, psel_cnt);
        end
        n_tests++;
        if (apb_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_apb_count: got %0d required 3", apb_q.size());
        end else if (apb_q[0].addr !== 12'h004 || apb_q[1].addr !== 12'h00C ||
                     apb_q[2].addr !== 12'h010 || apb_q[2].wr !== 1'b1 || apb_q[2].wdata !== wd) begin
            n_fail++;
            $display("FAIL b2b_apb_seq: got %h %h %h wr=%b wd=%h required 004 00c 010 wr=1 wd=%h",
                     apb_q[0].addr, apb_q[1].addr, apb_q[2].addr, apb_q[2].wr, apb_q[2].wdata, wd);
        end
        apb_q.delete();
    endtask

    task automatic test_reset_mid();
        bit seen;
        slv_waits = STUCK;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = $urandom; HWRITE = 1'b0;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge HCLK);
            if (PENABLE) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_access: got no ACCESS phase, required PENABLE=1");
        end
        HRESETN = 1'b0;
        @(negedge HCLK);
        n_tests++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got psel=%b pen=%b hready=%b required 0/0/1", PSEL, PENABLE, HREADYOUT);
        end
        HRESETN = 1'b1;
        model_hrdata = 32'h0;
        @(negedge HCLK);
        apb_q.delete();
    endtask

    task automatic test_random();
        int nw; logic rs; logic [31:0] rd; apb_t e;
        logic [31:0] addr; logic [31:0] wd; logic [31:0] dat;
        logic wr; logic err; int waits; int gap; int exp_w;
        for (int n = 0; n < 24; n++) begin
            addr  = $urandom;
            wd    = $urandom;
            dat   = $urandom;
            wr    = 1'($urandom);
            err   = ($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 3);
            do_xfer(addr, wr, wd, waits, err, dat, nw, rs, rd);
            exp_w = 2 + waits + (wr ? 1 : 0) + (err ? 1 : 0);
            if (!wr && !err) model_hrdata = dat;
            n_tests++;
            if (nw != exp_w || rs !== err || rd !== model_hrdata || psel_cnt != 2 + waits) begin
                n_fail++;
                $display("FAIL rand_xfer%0d: got waits=%0d resp=%b hrdata=%h psel=%0d required %0d/%b/%h/%0d",
                         n, nw, rs, rd, psel_cnt, exp_w, err, model_hrdata, 2 + waits);
            end
            n_tests++;
            if (apb_q.size() != 1) begin
                n_fail++;
                $display("FAIL rand_apb_count%0d: got %0d required 1", n, apb_q.size());
                apb_q.delete();
            end else begin
                e = apb_q.pop_front();
                if (e.addr !== addr[AW-1:0] || e.wr !== wr || (wr && e.wdata !== wd)) begin
                    n_fail++;
                    $display("FAIL rand_apb%0d: got addr=%h wr=%b wd=%h required addr=%h wr=%b wd=%h",
                             n, e.addr, e.wr, e.wdata, addr[AW-1:0], wr, wd);
                end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                HSEL = 1'($urandom); HTRANS = 2'($urandom_range(0, 1)); HADDR = $urandom;
                @(negedge HCLK);
                n_tests++;
                if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle%0d: got hready=%b hresp=%b psel=%b required 1/0/0",
                             n, HREADYOUT, HRESP, PSEL);
                end
            end
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int nw; logic rs; logic [31:0] rd;
        n_tests++;
        if (TIMEOUT_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag_init: got %b required 0", TIMEOUT_FLAG);
        end
        do_xfer($urandom, 1'b0, 32'h0, STUCK, 1'b0, $urandom, nw, rs, rd);
        n_tests++;
        if (nw != TMO + 2 || rs !== 1'b1 || rd !== model_hrdata || pen_cnt != TMO) begin
            n_fail++;
            $display("FAIL timeout_abort: got waits=%0d resp=%b hrdata=%h penable=%0d required %0d/1/%h/%0d",
                     nw, rs, rd, pen_cnt, TMO + 2, model_hrdata, TMO);
        end
        n_tests++;
        if (TIMEOUT_FLAG !== 1'b1 || apb_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_flag: got flag=%b apb_xfers=%0d required 1/0", TIMEOUT_FLAG, apb_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_wait_states();
        test_slverr_err2_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
